vending_machine_param: RTL

Parametrised successor to the single-price 5/10 coin vending FSM.
- Accumulates credit from three coin denominations against a configurable price.
- Tracks product stock and vends one item when the price is reached.
- Returns change or refunds serially, as one pulse per 5-unit coin.
- Sits between the coin acceptor front end and the dispense/change actuators.

---
 rtl/vending_machine_param.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vending_machine_param.sv
// vending_machine_param
// Coin-operated vending controller with a configurable price, stock tracking and
// serial change/refund (one change_pulse per returned 5-unit coin).
// Optional build macro VEND_SALES_COUNT_EN adds a saturating 16-bit sales counter
// output (sales_count); the default build leaves it out entirely.

module vending_machine_param #(
    parameter int PRICE_UNITS = 3,
    parameter int CREDIT_W    = 4,
    parameter int STOCK_W     = 8,
    parameter int STOCK_INIT  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                cancel,
    input  logic                restock,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic                vend,
    output logic                change_pulse,
    output logic                busy,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock
`ifdef VEND_SALES_COUNT_EN
    ,
    output logic [15:0]         sales_count
`endif
);

    // Price and constants sized to the datapath so every compare/subtract is width-matched.
    localparam logic [CREDIT_W:0]   PRICE_EXT  = (CREDIT_W+1)'(PRICE_UNITS);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE_UNITS);
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] CREDIT_ZERO = CREDIT_W'(0);
    localparam logic [STOCK_W-1:0]  STOCK_LOAD = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0]  STOCK_ONE  = STOCK_W'(1);
    localparam logic [STOCK_W-1:0]  STOCK_ZERO = STOCK_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VEND    = 3'd2,
        ST_CHANGE  = 3'd3,
        ST_REFUND  = 3'd4
    } state_t;

    // Coin code to credit units; code 00 is worth nothing and is always rejected.
    function automatic logic [CREDIT_W:0] coin_units(input logic [1:0] code);
        logic [CREDIT_W:0] units;
        case (code)
            2'b01:   units = (CREDIT_W+1)'(1);
            2'b10:   units = (CREDIT_W+1)'(2);
            2'b11:   units = (CREDIT_W+1)'(4);
            default: units = (CREDIT_W+1)'(0);
        endcase
        return units;
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic [CREDIT_W-1:0]   r_credit;
    logic [CREDIT_W-1:0]   w_credit_next;
    logic [STOCK_W-1:0]    r_stock;
    logic [STOCK_W-1:0]    w_stock_next;
    logic                  r_coin_accept;
    logic                  r_coin_reject;
    logic                  r_vend;
    logic                  r_change_pulse;
    logic                  w_accept_next;
    logic                  w_reject_next;
    logic                  w_vend_next;
    logic                  w_change_next;
    logic                  w_busy;
    logic                  w_sold_out;
    logic                  w_coin_ok;
    logic [CREDIT_W:0]     w_sum;
    logic [CREDIT_W-1:0]   w_remainder;

    // Status decoded only from registered state and stock.
    assign w_busy      = (r_state == ST_VEND) || (r_state == ST_CHANGE) || (r_state == ST_REFUND);
    assign w_sold_out  = (r_stock == STOCK_ZERO);
    assign w_coin_ok   = (coin_code != 2'b00) && !w_sold_out && !cancel;
    assign w_sum       = {1'b0, r_credit} + coin_units(coin_code);
    assign w_remainder = r_credit - PRICE_C;

    // Pulse outputs are registered from the state being entered so they line up with it.
    assign w_vend_next   = (w_state_next == ST_VEND);
    assign w_change_next = (w_state_next == ST_CHANGE) || (w_state_next == ST_REFUND);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, credit/stock update and output pulse decisions.
    always_comb begin
        w_state_next  = r_state;
        w_credit_next = r_credit;
        w_stock_next  = r_stock;
        w_accept_next = 1'b0;
        w_reject_next = 1'b0;
        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (coin_valid) begin
                    if (w_coin_ok) begin
                        w_accept_next = 1'b1;
                        w_credit_next = w_sum[CREDIT_W-1:0];
                        if (w_sum >= PRICE_EXT) begin
                            w_state_next = ST_VEND;
                        end else begin
                            w_state_next = ST_COLLECT;
                        end
                    end else begin
                        // A coin offered with cancel is bounced, then prior credit is refunded.
                        w_reject_next = 1'b1;
                        if (cancel && (r_state == ST_COLLECT)) begin
                            w_state_next = ST_REFUND;
                        end else begin
                            w_state_next = r_state;
                        end
                    end
                end else if (cancel && (r_state == ST_COLLECT)) begin
                    w_state_next = ST_REFUND;
                end else begin
                    w_state_next = r_state;
                end
                // Restock only outside busy states, so it never collides with the VEND decrement.
                if (restock) begin
                    w_stock_next = STOCK_LOAD;
                end else begin
                    w_stock_next = r_stock;
                end
            end
            ST_VEND: begin
                w_reject_next = coin_valid;
                w_stock_next  = r_stock - STOCK_ONE;
                w_credit_next = w_remainder;
                if (w_remainder != CREDIT_ZERO) begin
                    w_state_next = ST_CHANGE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                w_reject_next = coin_valid;
                // One unit returned per cycle; leave on the 1 -> 0 edge.
                if (r_credit <= CREDIT_ONE) begin
                    w_credit_next = CREDIT_ZERO;
                    w_state_next  = ST_IDLE;
                end else begin
                    w_credit_next = r_credit - CREDIT_ONE;
                    w_state_next  = r_state;
                end
            end
            default: begin
                w_credit_next = CREDIT_ZERO;
                w_state_next  = ST_IDLE;
            end
        endcase
    end

    // Credit, stock and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit       <= CREDIT_ZERO;
            r_stock        <= STOCK_LOAD;
            r_coin_accept  <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_vend         <= 1'b0;
            r_change_pulse <= 1'b0;
        end else begin
            r_credit       <= w_credit_next;
            r_stock        <= w_stock_next;
            r_coin_accept  <= w_accept_next;
            r_coin_reject  <= w_reject_next;
            r_vend         <= w_vend_next;
            r_change_pulse <= w_change_next;
        end
    end

`ifdef VEND_SALES_COUNT_EN
    logic [15:0] r_sales_count;

    // Saturating count of VEND cycles; restock leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sales_count <= 16'h0000;
        end else if ((r_state == ST_VEND) && (r_sales_count != 16'hFFFF)) begin
            r_sales_count <= r_sales_count + 16'h0001;
        end else begin
            r_sales_count <= r_sales_count;
        end
    end

    assign sales_count = r_sales_count;
`endif

    assign coin_accept  = r_coin_accept;
    assign coin_reject  = r_coin_reject;
    assign vend         = r_vend;
    assign change_pulse = r_change_pulse;
    assign busy         = w_busy;
    assign sold_out     = w_sold_out;
    assign credit       = r_credit;
    assign stock        = r_stock;

endmodule
